// File: rtl/game_state_ctrl_pkg.sv
// rtl/game_state_ctrl_pkg.sv - state encodings, coordinate width and screen limits for game_state_ctrl
package game_state_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_PLAY      = 3'd1,
      ST_SCAN      = 3'd2,
      ST_DEAD      = 3'd3,
      ST_LEVEL_UP  = 3'd4,
      ST_GAME_OVER = 3'd5
   } state_e;

   localparam int COORD_W  = 10;
   localparam int CAR_BITS = 2 * COORD_W;
   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   localparam logic [2:0] LEVEL_MAX = 3'd7;

   function automatic logic [2:0] level_inc(input logic [2:0] lvl);
      return (lvl == LEVEL_MAX) ? lvl : lvl + 3'd1;
   endfunction

endpackage

// File: rtl/game_state_ctrl_box_overlap.sv
// rtl/game_state_ctrl_box_overlap.sv - box_overlap: strict axis-aligned box overlap compare
// Sums are one bit wider than coordinates so edges near 1023 never wrap.
module box_overlap
   import game_state_ctrl_pkg::*;
#(
   parameter int A_W = 32,
   parameter int A_H = 32,
   parameter int B_W = 32,
   parameter int B_H = 32
) (
   input  logic [COORD_W-1:0] a_x_i,
   input  logic [COORD_W-1:0] a_y_i,
   input  logic [COORD_W-1:0] b_x_i,
   input  logic [COORD_W-1:0] b_y_i,
   output logic               overlap_o
);

   localparam logic [COORD_W:0] A_W_X = A_W[COORD_W:0];
   localparam logic [COORD_W:0] A_H_X = A_H[COORD_W:0];
   localparam logic [COORD_W:0] B_W_X = B_W[COORD_W:0];
   localparam logic [COORD_W:0] B_H_X = B_H[COORD_W:0];

   logic [COORD_W:0] a_x, a_y, b_x, b_y;

   assign a_x = {1'b0, a_x_i};
   assign a_y = {1'b0, a_y_i};
   assign b_x = {1'b0, b_x_i};
   assign b_y = {1'b0, b_y_i};

   assign overlap_o = (a_x < b_x + B_W_X) && (b_x < a_x + A_W_X) &&
                      (a_y < b_y + B_H_X) && (b_y < a_y + A_H_X);

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - per-frame collision scan, lives/level and game sequencing
// GOD_MODE_EN: collisions pulse hit but never cost a life.
module game_state_ctrl
   import game_state_ctrl_pkg::*;
#(
   parameter int NUM_CARS   = 4,
   parameter int LIVES      = 3,
   parameter int PLAYER_W   = 32,
   parameter int PLAYER_H   = 32,
   parameter int CAR_W      = 32,
   parameter int CAR_H      = 32,
   parameter int GOAL_Y     = 32,
   parameter int HIT_FRAMES = 30,
   parameter int WIN_FRAMES = 60
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         frame_tick,
   input  logic                         start,
   input  logic [COORD_W-1:0]           player_x,
   input  logic [COORD_W-1:0]           player_y,
   input  logic [CAR_BITS*NUM_CARS-1:0] car_xy,
   output logic [2:0]                   state,
   output logic [1:0]                   lives,
   output logic [2:0]                   level,
   output logic                         hit,
   output logic                         respawn,
   output logic                         freeze
);

`ifdef GOD_MODE_EN
   localparam bit GOD_MODE = 1'b1;
`else
   localparam bit GOD_MODE = 1'b0;
`endif

   localparam int IDX_W      = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;
   localparam int MAX_FRAMES = (HIT_FRAMES > WIN_FRAMES) ? HIT_FRAMES : WIN_FRAMES;
   localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_CARS - 1);
   localparam logic [CNT_W-1:0]   HIT_LAST   = CNT_W'(HIT_FRAMES - 1);
   localparam logic [CNT_W-1:0]   WIN_LAST   = CNT_W'(WIN_FRAMES - 1);
   localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
   localparam logic [COORD_W-1:0] GOAL_Y_C   = COORD_W'(GOAL_Y);

   state_e                       state_q, state_d;
   logic                         start_q;
   logic [COORD_W-1:0]           px_q, px_d, py_q, py_d;
   logic [CAR_BITS*NUM_CARS-1:0] cars_q, cars_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic                         found_q, found_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [1:0]                   lives_q, lives_d;
   logic [2:0]                   level_q, level_d;
   logic                         hit_q, hit_d;
   logic                         respawn_q, respawn_d;

   logic                start_rise;
   logic [CAR_BITS-1:0] cur_car;
   logic                car_hit;
   logic                found_all;
   logic                last_car;
   logic                lose_life;
   logic                goal;

   assign start_rise = start & ~start_q;
   assign last_car   = (idx_q == LAST_IDX);
   assign found_all  = found_q | car_hit;
   assign lose_life  = found_all & ~GOD_MODE;
   assign goal       = (py_q <= GOAL_Y_C);

   always_comb begin
      cur_car = cars_q[CAR_BITS-1:0];
      for (int i = 0; i < NUM_CARS; i++) begin
         if (idx_q == IDX_W'(i)) cur_car = cars_q[i*CAR_BITS +: CAR_BITS];
      end
   end

   box_overlap #(
      .A_W(PLAYER_W),
      .A_H(PLAYER_H),
      .B_W(CAR_W),
      .B_H(CAR_H)
   ) u_overlap (
      .a_x_i    (px_q),
      .a_y_i    (py_q),
      .b_x_i    (cur_car[COORD_W-1:0]),
      .b_y_i    (cur_car[CAR_BITS-1:COORD_W]),
      .overlap_o(car_hit)
   );

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: if (start_rise) state_d = ST_PLAY;
         ST_PLAY:               if (frame_tick) state_d = ST_SCAN;
         ST_SCAN: begin
            if (last_car) begin
               if (lose_life)  state_d = (lives_q <= 2'd1) ? ST_GAME_OVER : ST_DEAD;
               else if (goal)  state_d = ST_LEVEL_UP;
               else            state_d = ST_PLAY;
            end
         end
         ST_DEAD:     if (frame_tick && cnt_q == HIT_LAST) state_d = ST_PLAY;
         ST_LEVEL_UP: if (frame_tick && cnt_q == WIN_LAST) state_d = ST_PLAY;
         default:     state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      px_d      = px_q;
      py_d      = py_q;
      cars_d    = cars_q;
      idx_d     = idx_q;
      found_d   = found_q;
      cnt_d     = cnt_q;
      lives_d   = lives_q;
      level_d   = level_q;
      hit_d     = 1'b0;
      respawn_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start_rise) begin
               lives_d   = LIVES_INIT;
               level_d   = 3'd0;
               respawn_d = 1'b1;
            end
         end
         ST_PLAY: begin
            if (frame_tick) begin
               px_d    = player_x;
               py_d    = player_y;
               cars_d  = car_xy;
               idx_d   = '0;
               found_d = 1'b0;
            end
         end
         ST_SCAN: begin
            idx_d   = idx_q + IDX_W'(1);
            found_d = found_all;
            if (last_car) begin
               cnt_d = '0;
               hit_d = found_all;
               if (lose_life && lives_q != 2'd0) lives_d = lives_q - 2'd1;
               if (!lose_life && goal)           level_d = level_inc(level_q);
            end
         end
         ST_DEAD, ST_LEVEL_UP: begin
            if (frame_tick) begin
               cnt_d     = cnt_q + CNT_W'(1);
               respawn_d = (cnt_q == ((state_q == ST_DEAD) ? HIT_LAST : WIN_LAST));
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         start_q   <= 1'b0;
         px_q      <= '0;
         py_q      <= '0;
         cars_q    <= '0;
         idx_q     <= '0;
         found_q   <= 1'b0;
         cnt_q     <= '0;
         lives_q   <= LIVES_INIT;
         level_q   <= 3'd0;
         hit_q     <= 1'b0;
         respawn_q <= 1'b0;
      end else begin
         start_q   <= start;
         px_q      <= px_d;
         py_q      <= py_d;
         cars_q    <= cars_d;
         idx_q     <= idx_d;
         found_q   <= found_d;
         cnt_q     <= cnt_d;
         lives_q   <= lives_d;
         level_q   <= level_d;
         hit_q     <= hit_d;
         respawn_q <= respawn_d;
      end
   end

   assign state   = state_q;
   assign lives   = lives_q;
   assign level   = level_q;
   assign hit     = hit_q;
   assign respawn = respawn_q;
   assign freeze  = ~((state_q == ST_PLAY) || (state_q == ST_SCAN));

endmodule
